// File: rtl/ibex_pkg.sv
// Shared types and constants for the branch history table.
package ibex_pkg;

  // Controller phases: table initialisation, then normal operation.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bht_state_e;

  // 2-bit saturating counter encodings.
  localparam logic [1:0] BHT_CTR_WNT = 2'b01;  // weakly not-taken, init value
  localparam logic [1:0] BHT_CTR_MIN = 2'b00;  // strongly not-taken
  localparam logic [1:0] BHT_CTR_MAX = 2'b11;  // strongly taken

  // Guard count at which a blocked update wins over lookups.
  localparam logic [1:0] BHT_GUARD_MAX = 2'd3;

  // Saturating increment on taken, saturating decrement on not-taken.
  function automatic logic [1:0] bht_ctr_next(input logic [1:0] ctr,
                                              input logic       taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != BHT_CTR_MAX) res = ctr + 2'd1;
    end else begin
      if (ctr != BHT_CTR_MIN) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ibex_bht_ram.sv
// Single-ported counter storage: combinational read, synchronous write.
// The read is combinational so a read-modify-write completes in one cycle.
module ibex_bht_ram #(
  parameter int unsigned BhtEntries = 64
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(BhtEntries)-1:0] addr_i,
  input  logic [1:0]                    wdata_i,
  output logic [1:0]                    rdata_o
);

  logic [1:0] mem [BhtEntries];

  // Write the addressed counter on the rising edge.
  // NOTE: the array has no reset; the controller's INIT sweep writes every
  // entry, which keeps this a plain RAM instead of a wall of flops.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/ibex_bht_ctrl.sv
// Branch history table controller: init sweep, lookup/update arbitration,
// one-entry update buffer with a starvation guard.
module ibex_bht_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned BhtEntries = 64  // power of two, 4..1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lookup_req_i,
  input  logic [31:0] lookup_pc_i,
  output logic        lookup_gnt_o,
  output logic        lookup_rvalid_o,
  output logic        lookup_taken_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  output logic        upd_ready_o,
  output logic        init_done_o
);

  localparam int unsigned IdxW = $clog2(BhtEntries);

  bht_state_e      state_q, state_d;
  logic [IdxW-1:0] init_cnt_q, init_cnt_d;

  logic            buf_valid_q;
  logic [IdxW-1:0] buf_idx_q;
  logic            buf_taken_q;
  logic [1:0]      guard_q;

  logic            rvalid_q;
  logic            taken_q;

  logic            in_run;
  logic            force_upd;
  logic            upd_wr;
  logic            lookup_gnt;
  logic            upd_ready;
  logic            upd_accept;
  logic            blocked;

  logic            ram_we;
  logic [IdxW-1:0] ram_addr;
  logic [1:0]      ram_wdata;
  logic [1:0]      ram_rdata;

  logic [IdxW-1:0] lookup_idx;
  logic [IdxW-1:0] upd_idx;
  logic            unused_pc_bits;

  // Instructions are halfword aligned, so bit 0 never selects an entry.
  assign lookup_idx     = lookup_pc_i[IdxW:1];
  assign upd_idx        = upd_pc_i[IdxW:1];
  assign unused_pc_bits = ^{lookup_pc_i[31:IdxW+1], lookup_pc_i[0],
                            upd_pc_i[31:IdxW+1], upd_pc_i[0]};

  // Arbitration. Reset is folded in so every handshake output is low while
  // rst_ni is low, even if the state register still says RUN.
  assign in_run     = rst_ni && (state_q == RUN);
  assign force_upd  = in_run && buf_valid_q && (guard_q == BHT_GUARD_MAX);
  assign upd_wr     = in_run && buf_valid_q && (!lookup_req_i || force_upd);
  assign lookup_gnt = in_run && lookup_req_i && !force_upd;
  assign blocked    = in_run && buf_valid_q && lookup_req_i && !force_upd;
  assign upd_ready  = in_run && (!buf_valid_q || upd_wr);
  assign upd_accept = upd_valid_i && upd_ready;

  // State register for the INIT/RUN controller.
  // NOTE: clocked blocks use <= only, so every register samples the values
  // from before the edge regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state and the single RAM port: init sweep, buffered update or lookup.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ram_we     = 1'b0;
    ram_addr   = lookup_idx;
    ram_wdata  = BHT_CTR_WNT;
    unique case (state_q)
      INIT: begin
        ram_we   = 1'b1;
        ram_addr = init_cnt_q;
        if (init_cnt_q == IdxW'(BhtEntries - 1)) begin
          state_d = RUN;
        end else begin
          init_cnt_d = init_cnt_q + IdxW'(1);
        end
      end
      RUN: begin
        if (upd_wr) begin
          ram_we    = 1'b1;
          ram_addr  = buf_idx_q;
          ram_wdata = bht_ctr_next(ram_rdata, buf_taken_q);
        end
      end
      default: state_d = INIT;
    endcase
  end

  // One-entry update buffer and the count of cycles it has been starved.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_taken_q <= 1'b0;
      guard_q     <= '0;
    end else begin
      if (upd_accept) begin
        buf_valid_q <= 1'b1;
        buf_idx_q   <= upd_idx;
        buf_taken_q <= upd_taken_i;
      end else if (upd_wr) begin
        buf_valid_q <= 1'b0;
      end
      if (!buf_valid_q || upd_wr) begin
        guard_q <= '0;
      end else if (blocked) begin
        guard_q <= guard_q + 2'd1;
      end
    end
  end

  // Prediction response, one cycle after the lookup grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      rvalid_q <= lookup_gnt;
      taken_q  <= lookup_gnt & ram_rdata[1];
    end
  end

  ibex_bht_ram #(
    .BhtEntries(BhtEntries)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign lookup_gnt_o    = lookup_gnt;
  assign lookup_rvalid_o = rvalid_q;
  assign lookup_taken_o  = taken_q;
  assign upd_ready_o     = upd_ready;
  assign init_done_o     = in_run;

endmodule

// File: tb/tb_ibex_bht_ctrl.sv
// Directed testbench for ibex_bht_ctrl with BhtEntries = 64 (index = pc[6:1]).
module tb_ibex_bht_ctrl;

  logic        clk_i        = 1'b0;
  logic        rst_ni       = 1'b0;
  logic        lookup_req_i = 1'b0;
  logic [31:0] lookup_pc_i  = '0;
  logic        upd_valid_i  = 1'b0;
  logic [31:0] upd_pc_i     = '0;
  logic        upd_taken_i  = 1'b0;
  logic        lookup_gnt_o;
  logic        lookup_rvalid_o;
  logic        lookup_taken_o;
  logic        upd_ready_o;
  logic        init_done_o;

  int n_tests = 0;
  int n_fail  = 0;

  ibex_bht_ctrl #(.BhtEntries(64)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .lookup_req_i   (lookup_req_i),
    .lookup_pc_i    (lookup_pc_i),
    .lookup_gnt_o   (lookup_gnt_o),
    .lookup_rvalid_o(lookup_rvalid_o),
    .lookup_taken_o (lookup_taken_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_ready_o    (upd_ready_o),
    .init_done_o    (init_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Single granted lookup; checks grant, then rvalid/taken one cycle later.
  task automatic do_lookup(input logic [31:0] pc, input logic exp,
                           input string tag);
    lookup_req_i = 1'b1;
    lookup_pc_i  = pc;
    #1;
    check({tag, "_gnt"}, lookup_gnt_o, 1);
    tick();
    lookup_req_i = 1'b0;
    check({tag, "_rvalid"}, lookup_rvalid_o, 1);
    check({tag, "_taken"}, lookup_taken_o, exp);
  endtask

  // Update into an empty buffer with no lookup: accepted, written next cycle.
  task automatic do_update(input logic [31:0] pc, input logic taken);
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = taken;
    #1;
    check("upd_ready", upd_ready_o, 1);
    tick();
    upd_valid_i = 1'b0;
    tick();
  endtask

  logic [31:0] init_pcs [5] = '{32'h0, 32'h7E, 32'h42, 32'h80, 32'hFE};
  int cyc;

  initial begin
    // ---- reset: requests held high must not be granted ----
    lookup_req_i = 1'b1;
    lookup_pc_i  = 32'h80;
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h80;
    repeat (3) tick();
    check("rst_gnt", lookup_gnt_o, 0);
    check("rst_ready", upd_ready_o, 0);
    check("rst_rvalid", lookup_rvalid_o, 0);
    check("rst_taken", lookup_taken_o, 0);
    check("rst_done", init_done_o, 0);

    // ---- init sweep: nothing accepted, done after 64 cycles ----
    rst_ni = 1'b1;
    #1;
    check("init_gnt", lookup_gnt_o, 0);
    check("init_ready", upd_ready_o, 0);
    lookup_req_i = 1'b0;
    upd_valid_i  = 1'b0;
    cyc = 0;
    while (!init_done_o && cyc < 200) begin
      tick();
      cyc++;
    end
    check("init_latency", cyc, 64);

    // Every entry starts weakly not-taken.
    for (int i = 0; i < 5; i++) do_lookup(init_pcs[i], 1'b0, "init_lookup");
    tick();
    check("idle_rvalid", lookup_rvalid_o, 0);
    check("idle_taken", lookup_taken_o, 0);

    // ---- counter saturation on pc 0x80 (entry 0, starts at 1) ----
    do_update(32'h80, 1'b1);                 // 2
    do_update(32'h80, 1'b1);                 // 3
    do_lookup(32'h80, 1'b1, "ctr_up2");
    do_update(32'h80, 1'b1);                 // stays 3
    do_update(32'h80, 1'b0);                 // 2
    do_lookup(32'h80, 1'b1, "ctr_sat_dec1");
    do_update(32'h80, 1'b0);                 // 1
    do_lookup(32'h80, 1'b0, "ctr_dec2");
    do_update(32'h80, 1'b0);                 // 0
    do_update(32'h80, 1'b0);                 // stays 0
    do_update(32'h80, 1'b1);                 // 1
    do_lookup(32'h80, 1'b0, "ctr_floor_inc1");
    do_update(32'h80, 1'b1);                 // 2
    do_lookup(32'h80, 1'b1, "ctr_floor_inc2");

    // ---- starvation guard: update pc 0x10 (entry 8) vs lookups pc 0x20 ----
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h10;
    upd_taken_i  = 1'b1;
    lookup_req_i = 1'b1;
    lookup_pc_i  = 32'h20;
    #1;
    check("guard_acc_ready", upd_ready_o, 1);
    check("guard_acc_gnt", lookup_gnt_o, 1);
    tick();
    upd_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("guard_blk_gnt", lookup_gnt_o, 1);
      check("guard_blk_ready", upd_ready_o, 0);
      tick();
    end
    #1;
    check("guard_force_gnt", lookup_gnt_o, 0);
    check("guard_force_ready", upd_ready_o, 1);
    tick();
    check("guard_force_rvalid", lookup_rvalid_o, 0);
    #1;
    check("guard_after_gnt", lookup_gnt_o, 1);
    tick();
    lookup_req_i = 1'b0;
    do_lookup(32'h10, 1'b1, "guard_result");  // entry 8: 1 -> 2

    // ---- full buffer: second update pc 0x30 (entry 24) waits ----
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h10;
    upd_taken_i  = 1'b1;
    lookup_req_i = 1'b1;
    lookup_pc_i  = 32'h20;
    #1;
    tick();
    upd_pc_i = 32'h30;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_ready", upd_ready_o, 0);
      tick();
    end
    #1;
    check("full_ready_on_write", upd_ready_o, 1);
    check("full_force_gnt", lookup_gnt_o, 0);
    tick();
    upd_valid_i  = 1'b0;
    lookup_req_i = 1'b0;
    tick();
    do_lookup(32'h10, 1'b1, "full_first");   // entry 8: 3
    do_lookup(32'h30, 1'b1, "full_second");  // entry 24: 2

    // ---- read right after write; pc 0x100 aliases entry 0 (now 2) ----
    do_update(32'h80, 1'b0);                  // 1
    do_lookup(32'h100, 1'b0, "alias_pre");
    do_update(32'h100, 1'b1);                 // 2
    do_lookup(32'h100, 1'b1, "fwd_read");

    // ---- reset with a pending update and a live lookup ----
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h30;
    upd_taken_i  = 1'b1;
    lookup_req_i = 1'b1;
    lookup_pc_i  = 32'h10;
    #1;
    tick();
    rst_ni      = 1'b0;
    upd_valid_i = 1'b1;
    tick();
    check("rst2_gnt", lookup_gnt_o, 0);
    check("rst2_ready", upd_ready_o, 0);
    check("rst2_rvalid", lookup_rvalid_o, 0);
    check("rst2_taken", lookup_taken_o, 0);
    check("rst2_done", init_done_o, 0);

    // ---- reset again at init count 30 ----
    rst_ni       = 1'b1;
    lookup_req_i = 1'b0;
    upd_valid_i  = 1'b0;
    repeat (30) tick();
    check("midinit_done", init_done_o, 0);
    rst_ni = 1'b0;
    tick();
    check("midinit_rst_done", init_done_o, 0);
    rst_ni = 1'b1;
    cyc = 0;
    while (!init_done_o && cyc < 200) begin
      tick();
      cyc++;
    end
    check("reinit_latency", cyc, 64);
    repeat (2) tick();
    do_lookup(32'h30, 1'b0, "reinit_drop_pending");
    do_lookup(32'h80, 1'b0, "reinit_entry0");
    do_lookup(32'h10, 1'b0, "reinit_entry8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_bht_ctrl.md
IBEX_BHT_CTRL -- requirements
Module: ibex_bht_ctrl

Interface
REQ-001 Parameter BhtEntries, default 64, number of 2-bit counters; SHALL be a power of two, 4..1024.
REQ-002 Derived IdxW = log2(BhtEntries) SHALL be a localparam, not a port parameter.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_ni  input  1  reset; synchronous, active-low.
REQ-005 lookup_req_i  input  1  fetch requests a prediction.
REQ-006 lookup_pc_i  input  32  PC of the fetched instruction.
REQ-007 lookup_gnt_o  output  1  lookup accepted this cycle.
REQ-008 lookup_rvalid_o  output  1  prediction valid, one cycle after grant.
REQ-009 lookup_taken_o  output  1  predicted direction, qualified by lookup_rvalid_o.
REQ-010 upd_valid_i  input  1  resolved branch from execute.
REQ-011 upd_pc_i  input  32  PC of the resolved branch.
REQ-012 upd_taken_i  input  1  actual branch outcome.
REQ-013 upd_ready_o  output  1  update accepted when upd_valid_i && upd_ready_o.
REQ-014 init_done_o  output  1  table initialisation complete.

Function
REQ-015 Table SHALL hold BhtEntries 2-bit saturating counters; index = pc[IdxW:1].
REQ-016 Table SHALL be modelled as single-ported: at most one read (lookup) or one write (update) per cycle.
REQ-017 FSM states: INIT, RUN.
REQ-018 INIT: an IdxW-bit counter SHALL write 2'b01 (weakly not-taken) to one entry per cycle, 0 to BhtEntries-1; after the last entry -> RUN; init_done_o=1 from the first RUN cycle.
REQ-019 In INIT, lookup_gnt_o=0 and upd_ready_o=0.
REQ-020 In RUN, arbitration SHALL grant lookups over pending updates, subject to REQ-023.
REQ-021 The block SHALL hold one pending update (pc index, taken) in a 1-entry buffer; upd_ready_o = RUN && (buffer empty || buffer written this cycle).
REQ-022 Pending update write: new counter = taken ? min(ctr+1,3) : max(ctr-1,0), read and written in the granted cycle.
REQ-023 Starvation guard: a 2-bit counter SHALL count consecutive cycles in which a lookup blocks a pending update; at 3, the next cycle SHALL grant the update and set lookup_gnt_o=0; the counter SHALL clear on any update write or when the buffer is empty.
REQ-024 lookup_gnt_o = lookup_req_i && RUN && !(guard forcing update).
REQ-025 Granted lookup: lookup_rvalid_o=1 the next cycle, lookup_taken_o = bit 1 of the counter read; otherwise lookup_rvalid_o=0 and lookup_taken_o=0.
REQ-026 Lookup granted the cycle after an update write to the same index SHALL see the updated value (no stale read).
REQ-027 Update arriving while buffer empty and no lookup: SHALL be written the next cycle (buffer latency one cycle).
REQ-028 Buffer full with no write this cycle: upd_ready_o=0; execute holds the update.

Reset
REQ-029 rst_ni low at any clock edge, including mid-INIT or with a pending update, SHALL: enter INIT, clear the init counter, empty the buffer, clear the guard counter.
REQ-030 Output values during and immediately after reset: lookup_gnt_o=0, lookup_rvalid_o=0, lookup_taken_o=0, upd_ready_o=0, init_done_o=0.
REQ-031 Table contents SHALL NOT be reset directly; REQ-018 initialises them.

Structure
REQ-032 Counter constants (weakly not-taken = 2'b01, saturation limits) and the bht_state_e typedef (INIT, RUN) SHALL reside in ibex_pkg.
REQ-033 Counter storage SHALL be a sub-module ibex_bht_ram (single port, synchronous write, BhtEntries x 2); FSM, arbitration and buffer reside in ibex_bht_ctrl.

Verification
REQ-034 Reset, BhtEntries=64 -> init_done_o rises exactly 64 cycles after rst_ni high; every lookup then returns lookup_taken_o=0.
REQ-035 Two updates taken=1 to pc 0x80 -> lookup pc 0x80 returns taken=1; a third taken=1 saturates at 3; three taken=0 updates -> 0; a fourth stays at 0.
REQ-036 lookup_req_i held high, one pending update -> update written on the 4th blocked cycle, lookup_gnt_o=0 that cycle only.
REQ-037 Update pc 0x100 written, lookup pc 0x100 next cycle -> returns the updated counter bit.
REQ-038 rst_ni asserted at init count 30 -> INIT restarts from 0, init_done_o rises 64 cycles after release.
REQ-039 Buffer full, lookup every cycle, second upd_valid_i -> upd_ready_o=0 until the buffered write, then accepts.
